cfu_ctrl: RTL and testbench
===========================

# cfu_ctrl

CPU-side controller for the custom function unit (CFU) port. It accepts a decoded custom-0 instruction from the execute stage, issues it to `cfu` as a one-cycle `en` pulse with stable operands, waits out the CFU's `stall` signal, captures the result and returns it to writeback over a valid/ready handshake. It sits between the pipeline's execute stage and the `cfu` instance, and is the initiator for the CFU interface.

## Interface
- `TIMEOUT_CYCLES`, 1024: stall cycles tolerated before abort; only used when `CFU_TIMEOUT_EN` is defined.
- `clk_i`  in  1  clock; one clock for the whole block.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  pipeline flush; discard the in-flight request.
- `req_valid_i`  in  1  execute stage offers a CFU instruction.
- `req_ready_o`  out  1  controller can accept; high only in IDLE.
- `req_funct3_i`  in  3  instruction funct3.
- `req_funct7_i`  in  7  instruction funct7.
- `req_src1_i`  in  32  rs1 value.
- `req_src2_i`  in  32  rs2 value.
- `req_rd_i`  in  5  destination register.
- `rsp_valid_o`  out  1  result available for writeback.
- `rsp_ready_i`  in  1  writeback accepts the result.
- `rsp_data_o`  out  32  CFU result.
- `rsp_rd_o`  out  5  destination register of the result.
- `rsp_err_o`  out  1  result produced by timeout abort.
- `cfu_en_o`  out  1  issue strobe to CFU.
- `cfu_funct3_o`  out  3  funct3 to CFU.
- `cfu_funct7_o`  out  7  funct7 to CFU.
- `cfu_src1_o`  out  32  operand 1 to CFU.
- `cfu_src2_o`  out  32  operand 2 to CFU.
- `cfu_stall_i`  in  1  CFU busy.
- `cfu_rslt_i`  in  32  CFU registered result.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i` and no `flush_i`, latch funct3/funct7/src1/src2/rd, go ISSUE. Request with `flush_i` high is ignored.
- ISSUE: `cfu_en_o`=1 for exactly this cycle; go WAIT.
- WAIT: `cfu_en_o`=0, operand outputs hold latched values. In the first cycle with `cfu_stall_i`=0, capture `cfu_rslt_i` into `rsp_data_o`, clear `rsp_err_o`, go RESP (or IDLE if cancelled).
- RESP: `rsp_valid_o`=1; `rsp_data_o`/`rsp_rd_o`/`rsp_err_o` stable until `rsp_valid_o && rsp_ready_i`, then IDLE.
- Flush: in ISSUE or WAIT sets a cancel flag. The CFU op is not aborted: `cfu_en_o` still pulses in ISSUE, and WAIT still runs to completion. The result is then dropped, with no RESP, and the state returns to IDLE. Flush in RESP drops `rsp_valid_o` next cycle and returns to IDLE. Flush in IDLE has no effect.
- Simultaneous `flush_i` and `rsp_ready_i` in RESP: treated as consumed; IDLE either way.
- Operand outputs are zero in IDLE. `rsp_data_o` holds its last value outside RESP.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Reset values: `req_ready_o`=0 while `rst_ni` low, then 1 (IDLE). All other outputs 0. Cancel flag and timeout counter are 0.
- Reset mid-operation returns to IDLE immediately; the outstanding CFU op is forgotten.
- Latency with no stall: accept at cycle T, `cfu_en_o` at T+1, result sampled at T+2, `rsp_valid_o` at T+3.
- Each stall cycle in WAIT adds one cycle.
- Throughput: one instruction per 4 cycles minimum. No new request is accepted until IDLE.
- The CFU contract relied on is: the result is valid in the first non-stalled cycle after `en`.

## Configuration
- `CFU_TIMEOUT_EN` defined:
  - A counter increments for each WAIT cycle with `cfu_stall_i`=1.
  - When it reaches `TIMEOUT_CYCLES`, go RESP with `rsp_data_o`=32'hDEADBEEF and `rsp_err_o`=1, or go IDLE if cancelled.
  - The counter clears on entry to ISSUE.
- Not defined: no counter, WAIT waits indefinitely, and `rsp_err_o` is constant 0.

## Test plan
- Basic op: src1=3, src2=4, CFU adds, no stall → `cfu_en_o` is one cycle at T+1; `rsp_valid_o` at T+3 with data 7 and rd unchanged.
- Stall: CFU model holds `cfu_stall_i` for 5 cycles, src1=32'hFFFF_FFFF, src2=1 → `rsp_valid_o` at T+8, data 0; operands stable throughout WAIT.
- Backpressure: `rsp_ready_i` low for 3 cycles → data/rd stable, `req_ready_o`=0 until the cycle after the handshake.
- Flush in WAIT: assert `flush_i` during stall → no `rsp_valid_o`, IDLE after stall drops, next request 10+20 returns 30.
- Reset mid-WAIT: `rst_ni` low → all outputs 0 asynchronously; after release `req_ready_o`=1.
- Timeout (with `CFU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): stall held forever → `rsp_valid_o` after 16 stall cycles with data 32'hDEADBEEF and `rsp_err_o`=1.

Source files
------------

// File: rtl/cfu_ctrl_if.sv
// Bundle of execute-stage request, writeback response and CFU issue signals.
// master = cfu_ctrl (initiator towards the CFU), slave = surrounding pipeline/CFU.
interface cfu_ctrl_if;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [6:0]  req_funct7_i;
    logic [31:0] req_src1_i;
    logic [31:0] req_src2_i;
    logic [4:0]  req_rd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_err_o;
    logic        cfu_en_o;
    logic [2:0]  cfu_funct3_o;
    logic [6:0]  cfu_funct7_o;
    logic [31:0] cfu_src1_o;
    logic [31:0] cfu_src2_o;
    logic        cfu_stall_i;
    logic [31:0] cfu_rslt_i;

    modport master (
        input  flush_i, req_valid_i, req_funct3_i, req_funct7_i, req_src1_i,
               req_src2_i, req_rd_i, rsp_ready_i, cfu_stall_i, cfu_rslt_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_err_o,
               cfu_en_o, cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o
    );

    modport slave (
        output flush_i, req_valid_i, req_funct3_i, req_funct7_i, req_src1_i,
               req_src2_i, req_rd_i, rsp_ready_i, cfu_stall_i, cfu_rslt_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_err_o,
               cfu_en_o, cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o
    );
endinterface

// File: rtl/cfu_ctrl.sv
// CPU-side CFU controller: issue one custom-0 op, wait out stall, return result.
// Optional stall timeout abort enabled by defining CFU_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a new request, operand outputs zero
// ISSUE  | cfu_en pulse with latched operands
// WAIT   | holding operands until CFU stall drops (or timeout)
// RESP   | result presented to writeback until accepted or flushed
module cfu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    cfu_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        cfu_en_q;
    logic        cancel_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;

    logic accept;
    logic drop;
    logic timeout_hit;

    assign accept = (state_q == S_IDLE) && req_ready_q && bus.req_valid_i && !bus.flush_i;
    assign drop   = cancel_q || bus.flush_i;

`ifdef CFU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt_q;

    // Hit on the stall cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == S_WAIT) && bus.cfu_stall_i && (stall_cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_WAIT) && bus.cfu_stall_i) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cfu_en_q    <= 1'b0;
            cancel_q    <= 1'b0;
            rsp_data_q  <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
        end else begin
            cfu_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= S_ISSUE;
                        req_ready_q <= 1'b0;
                        cfu_en_q    <= 1'b1;
                        cancel_q    <= 1'b0;
                        funct3_q    <= bus.req_funct3_i;
                        funct7_q    <= bus.req_funct7_i;
                        src1_q      <= bus.req_src1_i;
                        src2_q      <= bus.req_src2_i;
                        rd_q        <= bus.req_rd_i;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    if (bus.flush_i) cancel_q <= 1'b1;
                end
                S_WAIT: begin
                    if (bus.flush_i) cancel_q <= 1'b1;
                    if (!bus.cfu_stall_i || timeout_hit) begin
                        if (drop) begin
                            // Cancelled op ran to completion; its result is discarded.
                            state_q     <= S_IDLE;
                            req_ready_q <= 1'b1;
                            cancel_q    <= 1'b0;
                            funct3_q    <= '0;
                            funct7_q    <= '0;
                            src1_q      <= '0;
                            src2_q      <= '0;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= timeout_hit;
                            rsp_data_q  <= timeout_hit ? 32'hDEAD_BEEF : bus.cfu_rslt_i;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i || bus.flush_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        cancel_q    <= 1'b0;
                        funct3_q    <= '0;
                        funct7_q    <= '0;
                        src1_q      <= '0;
                        src2_q      <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.rsp_rd_o     = rd_q;
    assign bus.rsp_err_o    = rsp_err_q;
    assign bus.cfu_en_o     = cfu_en_q;
    assign bus.cfu_funct3_o = funct3_q;
    assign bus.cfu_funct7_o = funct7_q;
    assign bus.cfu_src1_o   = src1_q;
    assign bus.cfu_src2_o   = src2_q;
endmodule

// File: tb/tb_cfu_ctrl.sv
// Self-checking bench for cfu_ctrl: vector table, random ops against a reference
// model, and hand-written flush/reset/timeout sequences.
module tb_cfu_ctrl;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;

    always #5 clk_i = ~clk_i;

    cfu_ctrl_if bus();

    cfu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        int          stall;
        int          bp;
        logic [31:0] exp_data;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int cfg_stall = 0;
    bit cfg_forever = 1'b0;
    int m_rem = 0;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_a, m_b;

    function automatic logic [31:0] cfu_func(logic [2:0] f3, logic [6:0] f7,
                                             logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a ^ b;
            3'd2:    return a - b;
            default: return a ^ {25'd0, f7};
        endcase
    endfunction

    // CFU behavioural model: stall/result decided mid-cycle for the next sampling edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_rem = 0;
            bus.cfu_stall_i = 1'b0;
            bus.cfu_rslt_i  = 32'd0;
        end else if (bus.cfu_en_o) begin
            m_rem = cfg_stall;
            m_f3 = bus.cfu_funct3_o;
            m_f7 = bus.cfu_funct7_o;
            m_a  = bus.cfu_src1_o;
            m_b  = bus.cfu_src2_o;
            bus.cfu_stall_i = 1'b1;
            bus.cfu_rslt_i  = 32'hBAD0_0000;
        end else if (cfg_forever || m_rem > 0) begin
            bus.cfu_stall_i = 1'b1;
            bus.cfu_rslt_i  = $urandom;
            if (m_rem > 0) m_rem = m_rem - 1;
        end else begin
            bus.cfu_stall_i = 1'b0;
            bus.cfu_rslt_i  = cfu_func(m_f3, m_f7, m_a, m_b);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                            bus.cfu_en_o, bus.cfu_funct3_o[1:0]}, 64'd0);
        chk({tag, "_fld"}, {49'd0, bus.cfu_funct3_o[2], bus.cfu_funct7_o, bus.rsp_rd_o,
                            bus.cfu_src2_o[1:0]}, 64'd0);
        chk({tag, "_data"}, {bus.rsp_data_o, bus.cfu_src1_o}, 64'd0);
        chk({tag, "_src2"}, {32'd0, bus.cfu_src2_o}, 64'd0);
    endtask

    task automatic start_req(input vec_t v);
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = v.f3;
        bus.req_funct7_i = v.f7;
        bus.req_src1_i   = v.s1;
        bus.req_src2_i   = v.s2;
        bus.req_rd_i     = v.rd;
        cfg_stall        = v.stall;
    endtask

    task automatic scramble_req();
        bus.req_valid_i  = 1'b0;
        bus.req_funct3_i = 3'($urandom);
        bus.req_funct7_i = 7'($urandom);
        bus.req_src1_i   = $urandom;
        bus.req_src2_i   = $urandom;
        bus.req_rd_i     = 5'($urandom);
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        chk("req_ready_idle", {63'd0, bus.req_ready_o}, 64'd1);
        start_req(v);
        bus.rsp_ready_i = 1'b0;
        tick();
        scramble_req();
        lat = 1;
        chk("en_issue", {63'd0, bus.cfu_en_o}, 64'd1);
        chk("ops_issue", {bus.cfu_src1_o, bus.cfu_src2_o}, {v.s1, v.s2});
        chk("fn_issue", {54'd0, bus.cfu_funct7_o, bus.cfu_funct3_o}, {54'd0, v.f7, v.f3});
        chk("ready_busy", {63'd0, bus.req_ready_o}, 64'd0);
        tick();
        lat = 2;
        chk("en_single", {63'd0, bus.cfu_en_o}, 64'd0);
        while (!bus.rsp_valid_o && lat < 40) begin
            chk("ops_hold", {bus.cfu_src1_o, bus.cfu_src2_o}, {v.s1, v.s2});
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(3 + v.stall));
        chk("rsp_data", {32'd0, bus.rsp_data_o}, {32'd0, v.exp_data});
        chk("rsp_rd_err", {58'd0, bus.rsp_err_o, bus.rsp_rd_o}, {58'd0, 1'b0, v.rd});
        for (int i = 0; i < v.bp; i++) begin
            tick();
            chk("bp_hold", {25'd0, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_rd_o, bus.rsp_data_o},
                           {25'd0, 1'b1, 1'b0, v.rd, v.exp_data});
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        chk("post_hs", {30'd0, bus.rsp_valid_o, bus.req_ready_o, bus.cfu_src1_o},
                       {30'd0, 1'b0, 1'b1, 32'd0});
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        tbl[0] = '{f3: 3'd0, f7: 7'h00, s1: 32'd3,          s2: 32'd4,          rd: 5'd5,  stall: 0, bp: 0, exp_data: 32'd7};
        tbl[1] = '{f3: 3'd0, f7: 7'h00, s1: 32'hFFFF_FFFF,  s2: 32'd1,          rd: 5'd9,  stall: 5, bp: 0, exp_data: 32'd0};
        tbl[2] = '{f3: 3'd1, f7: 7'h11, s1: 32'hF0F0_0F0F,  s2: 32'h0FF0_0FF0,  rd: 5'd31, stall: 1, bp: 3, exp_data: 32'hFF00_00FF};
        tbl[3] = '{f3: 3'd2, f7: 7'h00, s1: 32'd10,         s2: 32'd20,         rd: 5'd1,  stall: 2, bp: 1, exp_data: 32'hFFFF_FFF6};
        tbl[4] = '{f3: 3'd5, f7: 7'h7F, s1: 32'h1234_5600,  s2: 32'd0,          rd: 5'd0,  stall: 0, bp: 2, exp_data: 32'h1234_567F};

        bus.flush_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        scramble_req();

        #1 rst_ni = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        chk("ready_in_reset", {63'd0, bus.req_ready_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("ready_after_reset", {63'd0, bus.req_ready_o}, 64'd1);

        // flush in IDLE ignores the request
        bus.req_valid_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("idle_flush", {62'd0, bus.cfu_en_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});

        foreach (tbl[i]) do_op(tbl[i]);

        for (int n = 0; n < 30; n++) begin
            v.f3 = 3'($urandom);
            v.f7 = 7'($urandom);
            v.s1 = $urandom;
            v.s2 = $urandom;
            v.rd = 5'($urandom);
            v.stall = $urandom_range(0, 6);
            v.bp = $urandom_range(0, 3);
            v.exp_data = cfu_func(v.f3, v.f7, v.s1, v.s2);
            do_op(v);
        end

        // flush during WAIT stall: op completes silently, back to IDLE after stall drops
        v = '{f3: 3'd0, f7: 7'h00, s1: 32'd1, s2: 32'd1, rd: 5'd2, stall: 5, bp: 0, exp_data: 32'd2};
        start_req(v);
        tick();
        scramble_req();
        chk("flushwait_en", {63'd0, bus.cfu_en_o}, 64'd1);
        tick();
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            chk("flushwait_busy", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'd0);
            tick();
        end
        chk("flushwait_idle", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});
        v = '{f3: 3'd0, f7: 7'h00, s1: 32'd10, s2: 32'd20, rd: 5'd7, stall: 0, bp: 0, exp_data: 32'd30};
        do_op(v);

        // flush in ISSUE: en still pulses, result dropped
        v = '{f3: 3'd1, f7: 7'h00, s1: 32'd5, s2: 32'd6, rd: 5'd3, stall: 0, bp: 0, exp_data: 32'd3};
        start_req(v);
        tick();
        scramble_req();
        chk("flushissue_en", {63'd0, bus.cfu_en_o}, 64'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        tick();
        chk("flushissue_idle", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});

        // flush in RESP, alone and together with rsp_ready
        for (int m = 0; m < 2; m++) begin
            v = '{f3: 3'd0, f7: 7'h00, s1: 32'd8, s2: 32'd9, rd: 5'd4, stall: 0, bp: 0, exp_data: 32'd17};
            start_req(v);
            tick();
            scramble_req();
            tick();
            tick();
            chk("flushresp_valid", {31'd0, bus.rsp_valid_o, bus.rsp_data_o}, {31'd0, 1'b1, 32'd17});
            bus.flush_i = 1'b1;
            bus.rsp_ready_i = m[0];
            tick();
            bus.flush_i = 1'b0;
            bus.rsp_ready_i = 1'b0;
            chk("flushresp_drop", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});
            tick();
            chk("flushresp_noissue", {63'd0, bus.cfu_en_o}, 64'd0);
        end

        // reset during WAIT clears every output asynchronously
        v = '{f3: 3'd0, f7: 7'h55, s1: 32'hA5A5_A5A5, s2: 32'h1, rd: 5'd17, stall: 8, bp: 0, exp_data: 32'd0};
        start_req(v);
        tick();
        scramble_req();
        tick();
        tick();
        chk("midwait_src", {32'd0, bus.cfu_src1_o}, {32'd0, 32'hA5A5_A5A5});
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("midwait_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("midwait_ready", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});
        v = '{f3: 3'd2, f7: 7'h00, s1: 32'd50, s2: 32'd8, rd: 5'd12, stall: 1, bp: 0, exp_data: 32'd42};
        do_op(v);

`ifdef CFU_TIMEOUT_EN
        begin
            int lat;
            v = '{f3: 3'd0, f7: 7'h00, s1: 32'd1, s2: 32'd2, rd: 5'd21, stall: 0, bp: 0, exp_data: 32'd0};
            cfg_forever = 1'b1;
            start_req(v);
            tick();
            scramble_req();
            lat = 1;
            while (!bus.rsp_valid_o && lat < 60) begin
                tick();
                lat++;
            end
            chk("timeout_latency", 64'(lat), 64'd18);
            chk("timeout_data", {31'd0, bus.rsp_err_o, bus.rsp_data_o}, {31'd0, 1'b1, 32'hDEAD_BEEF});
            chk("timeout_rd", {59'd0, bus.rsp_rd_o}, {59'd0, 5'd21});
            bus.rsp_ready_i = 1'b1;
            tick();
            bus.rsp_ready_i = 1'b0;
            cfg_forever = 1'b0;
            chk("timeout_idle", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, {62'd0, 1'b0, 1'b1});
        end
`else
        // without the timeout a long stall simply waits it out
        v = '{f3: 3'd1, f7: 7'h00, s1: 32'hFFFF_0000, s2: 32'h00FF_FF00, rd: 5'd21, stall: 20, bp: 0,
              exp_data: 32'hFF00_FF00};
        do_op(v);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
